// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared FSM states, load-size encodings and the MEM/WB register layout.
package writeback_stage_pkg;
    localparam int WB_XLEN = 64;
    localparam int WB_REG_ADDR_W = 5;

    typedef enum logic [1:0] {IDLE, WRITE, RELEASE} wb_state_e;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;
    localparam logic [2:0] SIZE_D = 3'b011;

    typedef struct packed {
        logic [WB_XLEN-1:0]       loaded_data;
        logic [WB_XLEN-1:0]       alu_data;
        logic [WB_REG_ADDR_W-1:0] rd;
        logic                     reg_write;
        logic                     mem_to_reg;
        logic [2:0]               data_size;
        logic                     load_unsigned;
    } mem_wb_struct;
endpackage

// File: rtl/writeback_stage_load_extender.sv
// load_extender: aligns, truncates and sign/zero-extends a load field out of a raw doubleword.
module load_extender
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  logic [2:0]      size,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] result
);
    logic            is_d;
    logic [2:0]      off;
    logic [XLEN-1:0] sh;
    logic            sx;
    always_comb begin
        is_d = size[2] || size == SIZE_D;
        // Misaligned low offset bits are dropped so the field starts on a size boundary
        off = is_d ? 3'd0 : size == SIZE_W ? {offset[2], 2'b00} : size == SIZE_H ? {offset[2:1], 1'b0} : offset;
        sh = data >> {off, 3'b000};
        sx = ~load_unsigned;
        result = is_d ? sh :
                 size == SIZE_W ? {{(XLEN-32){sx & sh[31]}}, sh[31:0]} :
                 size == SIZE_H ? {{(XLEN-16){sx & sh[15]}}, sh[15:0]} :
                                  {{(XLEN-8){sx & sh[7]}}, sh[7:0]};
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB capture, result select and single-cycle register-file write with retire counter.
// Optional macro WB_BYPASS_EN adds decode-stage forwarding outputs mirroring the WRITE-cycle write.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_done,
    input  logic [XLEN-1:0]       loaded_data_in,
    input  logic [XLEN-1:0]       alu_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [2:0]            data_size_in,
    input  logic                  load_unsigned_in,
    output logic                  mem_wb_pipeline_valid,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_data,
`ifdef WB_BYPASS_EN
    output logic                  bypass_valid,
    output logic [REG_ADDR_W-1:0] bypass_addr,
    output logic [XLEN-1:0]       bypass_data,
`endif
    output logic                  wb_done,
    output logic [63:0]           retired_count
);
    wb_state_e       state;
    mem_wb_struct    mw;
    logic [XLEN-1:0] load_ext;

    load_extender #(.XLEN(XLEN)) u_ext (
        .data          (mw.loaded_data),
        .offset        (mw.alu_data[2:0]),
        .size          (mw.data_size),
        .load_unsigned (mw.load_unsigned),
        .result        (load_ext)
    );

    assign rf_write_addr = mw.rd;
    assign rf_write_data = mw.mem_to_reg ? load_ext : mw.alu_data;

`ifdef WB_BYPASS_EN
    assign bypass_valid = rf_write_enable;
    assign bypass_addr  = state == WRITE ? mw.rd : '0;
    assign bypass_data  = state == WRITE ? rf_write_data : '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            mw                    <= '0;
            mem_wb_pipeline_valid <= 1'b0;
            rf_write_enable       <= 1'b0;
            wb_done               <= 1'b0;
            retired_count         <= '0;
        end else begin
            case (state)
                IDLE: if (memory_done) begin
                    mw <= '{loaded_data: loaded_data_in, alu_data: alu_data_in, rd: rd_in,
                            reg_write: reg_write_in, mem_to_reg: mem_to_reg_in,
                            data_size: data_size_in, load_unsigned: load_unsigned_in};
                    mem_wb_pipeline_valid <= 1'b1;
                    rf_write_enable       <= reg_write_in && rd_in != '0;
                    wb_done               <= 1'b1;
                    state                 <= WRITE;
                end
                WRITE: begin
                    rf_write_enable <= 1'b0;
                    wb_done         <= 1'b0;
                    retired_count   <= retired_count + 64'd1;
                    state           <= RELEASE;
                end
                RELEASE: if (!memory_done) begin
                    mem_wb_pipeline_valid <= 1'b0;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scoreboard bench for writeback_stage.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memory_done = 1'b0;
    logic [63:0] loaded_data_in = '0;
    logic [63:0] alu_data_in = '0;
    logic [4:0]  rd_in = '0;
    logic        reg_write_in = 1'b0;
    logic        mem_to_reg_in = 1'b0;
    logic [2:0]  data_size_in = '0;
    logic        load_unsigned_in = 1'b0;
    logic        mem_wb_pipeline_valid;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [63:0] rf_write_data;
    logic        wb_done;
    logic [63:0] retired_count;
`ifdef WB_BYPASS_EN
    logic        bypass_valid;
    logic [4:0]  bypass_addr;
    logic [63:0] bypass_data;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_count = '0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .memory_done           (memory_done),
        .loaded_data_in        (loaded_data_in),
        .alu_data_in           (alu_data_in),
        .rd_in                 (rd_in),
        .reg_write_in          (reg_write_in),
        .mem_to_reg_in         (mem_to_reg_in),
        .data_size_in          (data_size_in),
        .load_unsigned_in      (load_unsigned_in),
        .mem_wb_pipeline_valid (mem_wb_pipeline_valid),
        .rf_write_enable       (rf_write_enable),
        .rf_write_addr         (rf_write_addr),
        .rf_write_data         (rf_write_data),
`ifdef WB_BYPASS_EN
        .bypass_valid          (bypass_valid),
        .bypass_addr           (bypass_addr),
        .bypass_data           (bypass_data),
`endif
        .wb_done               (wb_done),
        .retired_count         (retired_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] alu, input logic [63:0] ld, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic [2:0] size, input logic uns,
                          input int hold, input logic exp_we, input logic [63:0] exp_data);
        exp_t e;
        int   n;
        @(negedge clk);
        alu_data_in = alu; loaded_data_in = ld; rd_in = rd; reg_write_in = rw;
        mem_to_reg_in = m2r; data_size_in = size; load_unsigned_in = uns; memory_done = 1'b1;
        sb.push_back('{we: exp_we, addr: rd, data: exp_data});
        @(negedge clk);
        n = 0;
        while (!wb_done && n < 4) begin @(negedge clk); n++; end
        check("wb_latency", 64'(n), 64'd0);
        if (wb_done && sb.size() > 0) begin
            e = sb.pop_front();
            check("we", {63'd0, rf_write_enable}, {63'd0, e.we});
            check("addr", {59'd0, rf_write_addr}, {59'd0, e.addr});
            check("data", rf_write_data, e.data);
            check("valid_write", {63'd0, mem_wb_pipeline_valid}, 64'd1);
`ifdef WB_BYPASS_EN
            check("bypass_valid", {63'd0, bypass_valid}, {63'd0, e.we});
            check("bypass_data", bypass_data, e.data);
`endif
            exp_count++;
        end
        if (hold == 0) memory_done = 1'b0;
        @(negedge clk);
        check("valid_release", {63'd0, mem_wb_pipeline_valid}, 64'd1);
        check("we_release", {63'd0, rf_write_enable}, 64'd0);
        check("done_release", {63'd0, wb_done}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("valid_hold", {63'd0, mem_wb_pipeline_valid}, 64'd1);
            check("we_hold", {63'd0, rf_write_enable | wb_done}, 64'd0);
        end
        memory_done = 1'b0;
        @(negedge clk);
        check("valid_low", {63'd0, mem_wb_pipeline_valid}, 64'd0);
        check("count", retired_count, exp_count);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, mem_wb_pipeline_valid}, 64'd0);
        check("rst_we", {63'd0, rf_write_enable}, 64'd0);
        check("rst_addr", {59'd0, rf_write_addr}, 64'd0);
        check("rst_data", rf_write_data, 64'd0);
        check("rst_done", {63'd0, wb_done}, 64'd0);
        check("rst_count", retired_count, 64'd0);
        reset = 1'b0;

        run_op(64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 3'b011, 1'b0, 0, 1'b1, 64'h1234);
        run_op(64'h7, 64'h80FF_0000_0000_0000, 5'd6, 1'b1, 1'b1, 3'b000, 1'b0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(64'h6, 64'h80FF_0000_0000_0000, 5'd7, 1'b1, 1'b1, 3'b000, 1'b1, 0, 1'b1, 64'hFF);
        run_op(64'h5, 64'h8765_4321_0000_0000, 5'd8, 1'b1, 1'b1, 3'b010, 1'b0, 0, 1'b1, 64'hFFFF_FFFF_8765_4321);
        run_op(64'h3, 64'h0000_0000_8001_0000, 5'd9, 1'b1, 1'b1, 3'b001, 1'b0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
        run_op(64'h3, 64'h0000_0000_8001_0000, 5'd10, 1'b1, 1'b1, 3'b001, 1'b1, 0, 1'b1, 64'h8001);
        run_op(64'h7, 64'h0123_4567_89AB_CDEF, 5'd11, 1'b1, 1'b1, 3'b100, 1'b0, 0, 1'b1, 64'h0123_4567_89AB_CDEF);
        run_op(64'h55, 64'h0, 5'd0, 1'b1, 1'b0, 3'b011, 1'b0, 0, 1'b0, 64'h55);
        run_op(64'h66, 64'h0, 5'd12, 1'b0, 1'b0, 3'b011, 1'b0, 0, 1'b0, 64'h66);
        run_op(64'hBEEF, 64'h0, 5'd13, 1'b1, 1'b0, 3'b011, 1'b0, 5, 1'b1, 64'hBEEF);

        @(negedge clk);
        alu_data_in = 64'hABC; rd_in = 5'd14; reg_write_in = 1'b1; mem_to_reg_in = 1'b0; memory_done = 1'b1;
        @(negedge clk);
        check("rstw_we", {63'd0, rf_write_enable}, 64'd1);
        reset = 1'b1;
        memory_done = 1'b0;
        @(negedge clk);
        check("rstw_we_after", {63'd0, rf_write_enable}, 64'd0);
        check("rstw_done", {63'd0, wb_done}, 64'd0);
        check("rstw_valid", {63'd0, mem_wb_pipeline_valid}, 64'd0);
        check("rstw_count", retired_count, 64'd0);
        check("rstw_data", rf_write_data, 64'd0);
        reset = 1'b0;
        exp_count = '0;
        repeat (2) begin
            @(negedge clk);
            check("rstw_quiet", {63'd0, rf_write_enable | wb_done}, 64'd0);
        end

        run_op(64'h77, 64'h0, 5'd3, 1'b1, 1'b0, 3'b011, 1'b0, 0, 1'b1, 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
